arbt_wrr: RTL and testbench
===========================

Name: arbt_wrr

Overview:
Weighted round-robin arbiter with a registered data mux. It shares one downstream consumer, which uses a rdy/ack handshake, among ARBT_WIDTH requesters. Each requester gets up to wght_i[i] consecutive grants before ownership rotates. It sits in the same place as the fixed-priority arbiter of the arbt family and replaces it where starvation-free sharing is required. It has the same req/gnt/data/rdy/ack contract.

Parameters:
DATA_WIDTH, 32, width of each data word
ARBT_WIDTH, 4, number of requesters; power of two, >= 2
WGHT_WIDTH, 4, width of each weight and of the credit counter
RESET_VAL, {DATA_WIDTH{1'b0}}, reset value of data_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
data_i  in  [DATA_WIDTH-1:0] x [0:ARBT_WIDTH-1]  per-requester data, valid while req_i[i]=1
req_i  in  1 x [0:ARBT_WIDTH-1]  request; means "an item exists beyond those already granted"
gnt_o  out  1 x [0:ARBT_WIDTH-1]  registered one-cycle grant pulse; the requester's item is consumed
wght_i  in  [WGHT_WIDTH-1:0] x [0:ARBT_WIDTH-1]  quasi-static weights; value 0 is treated as 1
data_o  out  DATA_WIDTH  registered granted data
rdy_o  out  1  data_o holds an unacknowledged item
ack_i  in  1  consumer accepts data_o; honoured only while rdy_o=1

Behaviour:
- Reset, asynchronous and usable at any time: gnt_o all 0, data_o=RESET_VAL, rdy_o=0, state=IDLE, ptr_q=ARBT_WIDTH-1, cnt_q=0. An in-flight item is dropped.
- FSM state is IDLE or PEND; rdy_o = (state==PEND).
- Grant opportunity exists when state==IDLE, or when state==PEND and ack_i=1 (back-to-back).
- Selection happens at an opportunity when any req_i is set:
  - If req_i[ptr_q]=1 and cnt_q!=0, the owner keeps the grant: sel=ptr_q, cnt_d=cnt_q-1.
  - Otherwise sel = first j with req_i[j]=1, searching cyclically from ptr_q+1. Then ptr_d=j and cnt_d=max(wght_i[j],1)-1.
  - An owner that is not requesting forfeits its remaining credit.
- At an opportunity with no request:
  - From PEND with ack, go to IDLE.
  - ptr_q and cnt_q are unchanged.
- On a selection, in the next cycle:
  - gnt_o[sel]=1 for exactly one cycle; all other gnt_o are 0.
  - data_o=data_i[sel].
  - state=PEND.
- Latency: a request in cycle N while IDLE gives gnt_o, data_o and rdy_o in cycle N+1.
- Throughput: with ack_i held at 1 and continuous requests, one item per cycle.
- data_o holds its value while PEND without ack, and holds its last value while IDLE.
- gnt_o is 0 in every cycle not following a selection.
- Requester contract: req_i[i] in the gnt_o[i] cycle already excludes the granted item.
- Changes to wght_i take effect only at the next credit load.
- ack_i while IDLE is ignored.
- Assertions:
  - $onehot0(gnt_o).
  - rdy_o rises only one cycle after an opportunity with at least one request.
  - data_o is stable while rdy_o && !ack_i.
  - Static checks: ARBT_WIDTH is a power of two; WGHT_WIDTH >= 1.

Decomposition:
- Shared package arbt_pkg:
  - arbt_state_t enum {ARBT_IDLE, ARBT_PEND}.
  - Function arbt_rot_first(req, start) returning the index of the first set bit searching cyclically from start.
- Sub-module arbt_rr_sel: combinational rotating priority encoder.
  - Inputs: req vector and ptr.
  - Outputs: idx and a valid flag.
  - Reusable by future round-robin variants.
- Top level holds the FSM, ptr/cnt registers, gnt/data registers and SVA.

Test Plan:
- Single requester: ARBT_WIDTH=4, weights all 1, req_i[2]=1 for one cycle, ack_i=1 in the rdy cycle -> gnt_o[2] pulse at N+1, data_o=data_i[2], rdy_o=1 in N+1 only, then IDLE.
- Weighted sharing: wght={3,1,1,1}, req 0 and 1 continuously, ack_i=1 always -> grant sequence 0,0,0,1,0,0,0,1, one per cycle.
- Back-pressure: two requesters, ack_i=0 for 5 cycles -> single gnt_o pulse, data_o stable, rdy_o=1, no further gnt until ack.
- Credit forfeit and wrap: ptr at 3 with credit left, req_i[3] drops while req_i[0]=1 -> grant to 0 and credit reloaded from wght_i[0]; weight 0 behaves as 1.
- Simultaneous events and reset: ack_i together with new requests gives a back-to-back grant with no IDLE cycle. rst_ni asserted mid-PEND -> outputs return to reset values immediately (asynchronously). After release, the first grant goes to requester 0 when all request.

Source files
------------

// File: rtl/arbt_pkg.sv
// Shared types and helpers for the arbt arbiter family.
// Rotating first-set search used by the round-robin selectors.
package arbt_pkg;

  typedef enum logic {
    ARBT_IDLE,
    ARBT_PEND
  } arbt_state_t;

  localparam int unsigned ARBT_MAX_WIDTH = 64;
  localparam int unsigned ARBT_MAX_PW    = $clog2(ARBT_MAX_WIDTH);

  // width must be a power of two; returns start when nothing is set
  function automatic int unsigned arbt_rot_first(
    input logic [ARBT_MAX_WIDTH-1:0] req,
    input int unsigned               start,
    input int unsigned               width
  );
    int unsigned idx;
    logic        found;
    arbt_rot_first = start;
    found          = 1'b0;
    for (int unsigned k = 0; k < ARBT_MAX_WIDTH; k++) begin
      idx = (start + k) & (width - 1);
      if (!found && (k < width) && req[idx[ARBT_MAX_PW-1:0]]) begin
        arbt_rot_first = idx;
        found          = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arbt_rr_sel.sv
// Combinational rotating priority encoder: first request strictly after ptr_i, wrapping.
// Zero latency; no flow control of its own.
module arbt_rr_sel
  import arbt_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    idx_o,
  output logic             vld_o
);

  logic [PW-1:0] start;

  assign start = ptr_i + PW'(1);
  assign idx_o = PW'(arbt_rot_first(ARBT_MAX_WIDTH'(req_i), 32'(start), WIDTH));
  assign vld_o = |req_i;

endmodule

// File: rtl/arbt_wrr.sv
// Weighted round-robin arbiter with registered grant/data; grant to output in one cycle.
// Holds data_o and blocks new grants while rdy_o is high and ack_i is low.
module arbt_wrr
  import arbt_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ARBT_WIDTH = 4,
  parameter int unsigned          WGHT_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i [0:ARBT_WIDTH-1],
  input  logic [ARBT_WIDTH-1:0] req_i,
  output logic [ARBT_WIDTH-1:0] gnt_o,
  input  logic [WGHT_WIDTH-1:0] wght_i [0:ARBT_WIDTH-1],
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rdy_o,
  input  logic                  ack_i
);

  localparam int unsigned PW = $clog2(ARBT_WIDTH);

  if ((ARBT_WIDTH < 2) || ((ARBT_WIDTH & (ARBT_WIDTH - 1)) != 0) || (ARBT_WIDTH > ARBT_MAX_WIDTH))
  begin : g_bad_width
    $error("arbt_wrr: ARBT_WIDTH must be a power of two in [2, ARBT_MAX_WIDTH]");
  end
  if (WGHT_WIDTH < 1) begin : g_bad_wght
    $error("arbt_wrr: WGHT_WIDTH must be at least 1");
  end

  arbt_state_t           state_q;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [WGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ARBT_WIDTH-1:0] gnt_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [PW-1:0] rr_idx;
  logic          rr_vld;
  logic          opp;
  logic          keep;
  logic [PW-1:0] sel_idx;

  arbt_rr_sel #(
    .WIDTH (ARBT_WIDTH)
  ) u_rr_sel (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

  assign opp = (state_q == ARBT_IDLE) || ack_i;

  // A non-requesting owner loses its leftover credit; weight 0 loads like weight 1.
  always_comb begin
    keep    = req_i[ptr_q] && (cnt_q != '0);
    sel_idx = keep ? ptr_q : rr_idx;
    ptr_d   = sel_idx;
    if (keep) begin
      cnt_d = cnt_q - WGHT_WIDTH'(1);
    end else if (wght_i[rr_idx] == '0) begin
      cnt_d = '0;
    end else begin
      cnt_d = wght_i[rr_idx] - WGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARBT_IDLE;
      ptr_q   <= PW'(ARBT_WIDTH - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= RESET_VAL;
    end else begin
      gnt_q <= '0;
      if (opp) begin
        if (rr_vld) begin
          state_q <= ARBT_PEND;
          ptr_q   <= ptr_d;
          cnt_q   <= cnt_d;
          gnt_q   <= ARBT_WIDTH'(1) << sel_idx;
          data_q  <= data_i[sel_idx];
        end else begin
          state_q <= ARBT_IDLE;
        end
      end
    end
  end

  assign gnt_o  = gnt_q;
  assign data_o = data_q;
  assign rdy_o  = (state_q == ARBT_PEND);

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_rdy_rise   : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  $rose(rdy_o) |-> $past(opp && rr_vld));
  a_data_hold  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  (rdy_o && !ack_i) |=> $stable(data_o));

endmodule

// File: tb/tb_arbt_wrr.sv
// Randomised and directed bench for arbt_wrr against a cycle-level reference model.
module tb_arbt_wrr;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] data_i [0:3];
  logic [3:0]  req_i;
  logic [3:0]  gnt_o;
  logic [3:0]  wght_i [0:3];
  logic [31:0] data_o;
  logic        rdy_o;
  logic        ack_i;

  int nvec = 0;
  int nerr = 0;

  // reference model state: current owner, its remaining credit, pending flag
  int          m_owner;
  int          m_credit;
  bit          m_busy;
  logic [3:0]  m_gnt;
  logic [31:0] m_data;

  always #5 clk_i = ~clk_i;

  arbt_wrr dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (data_i),
    .req_i  (req_i),
    .gnt_o  (gnt_o),
    .wght_i (wght_i),
    .data_o (data_o),
    .rdy_o  (rdy_o),
    .ack_i  (ack_i)
  );

  task automatic model_reset();
    m_owner  = 3;
    m_credit = 0;
    m_busy   = 0;
    m_gnt    = 4'b0;
    m_data   = 32'h0;
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (!m_busy || ack_i) begin
      if (req_i != 4'b0) begin
        if (req_i[m_owner] && m_credit > 0) begin
          g = m_owner;
          m_credit = m_credit - 1;
        end else begin
          for (int k = 1; k <= 4; k++)
            if (g < 0 && req_i[(m_owner + k) % 4]) g = (m_owner + k) % 4;
          m_owner  = g;
          m_credit = (wght_i[g] == 0) ? 0 : int'(wght_i[g]) - 1;
        end
        m_data = data_i[g];
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end
    m_gnt = (g >= 0) ? (4'b0001 << g) : 4'b0000;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = 4'b0;
    ack_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic set_weights(input logic [3:0] w0, w1, w2, w3);
    wght_i[0] = w0; wght_i[1] = w1; wght_i[2] = w2; wght_i[3] = w3;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) data_i[i] = 32'hD000_0000 | (i << 8) | $urandom_range(0, 255);
  endtask

  task automatic test_reset();
    set_weights(1, 1, 1, 1);
    set_data();
    do_reset();
    nvec++;
    if (gnt_o !== 4'b0 || data_o !== 32'h0 || rdy_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset: gnt=%b data=%h rdy=%b, want gnt=0000 data=0 rdy=0", gnt_o, data_o, rdy_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] d2;
    do_reset();
    set_data();
    d2 = data_i[2];
    req_i = 4'b0100;
    tick();
    nvec++;
    if (gnt_o !== 4'b0100 || data_o !== d2 || rdy_o !== 1'b1 || m_gnt !== 4'b0100) begin
      nerr++;
      $display("FAIL single_grant: gnt=%b data=%h rdy=%b, want gnt=0100 data=%h rdy=1", gnt_o, data_o, rdy_o, d2);
    end
    req_i = 4'b0;
    ack_i = 1'b1;
    set_data();
    tick();
    nvec++;
    if (gnt_o !== 4'b0 || data_o !== d2 || rdy_o !== 1'b0) begin
      nerr++;
      $display("FAIL single_idle: gnt=%b data=%h rdy=%b, want gnt=0000 data=%h rdy=0", gnt_o, data_o, rdy_o, d2);
    end
  endtask

  task automatic test_weighted();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [3:0] want;
    set_weights(3, 1, 1, 1);
    do_reset();
    req_i = 4'b0011;
    ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_data();
      tick();
      want = 4'b0001 << exp_seq[i];
      nvec++;
      if (gnt_o !== want || rdy_o !== 1'b1 || data_o !== m_data || m_gnt !== want) begin
        nerr++;
        $display("FAIL weighted[%0d]: gnt=%b rdy=%b data=%h, want gnt=%b rdy=1 data=%h",
                 i, gnt_o, rdy_o, data_o, want, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d1;
    set_weights(1, 1, 1, 1);
    do_reset();
    set_data();
    d0 = data_i[0];
    req_i = 4'b0011;
    ack_i = 1'b0;
    tick();
    nvec++;
    if (gnt_o !== 4'b0001 || data_o !== d0 || rdy_o !== 1'b1) begin
      nerr++;
      $display("FAIL bp_first: gnt=%b data=%h rdy=%b, want gnt=0001 data=%h rdy=1", gnt_o, data_o, rdy_o, d0);
    end
    for (int i = 0; i < 5; i++) begin
      set_data();
      tick();
      nvec++;
      if (gnt_o !== 4'b0 || data_o !== d0 || rdy_o !== 1'b1) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: gnt=%b data=%h rdy=%b, want gnt=0000 data=%h rdy=1",
                 i, gnt_o, data_o, rdy_o, d0);
      end
    end
    d1 = data_i[1];
    ack_i = 1'b1;
    tick();
    nvec++;
    if (gnt_o !== 4'b0010 || data_o !== d1 || rdy_o !== 1'b1) begin
      nerr++;
      $display("FAIL bp_release: gnt=%b data=%h rdy=%b, want gnt=0010 data=%h rdy=1", gnt_o, data_o, rdy_o, d1);
    end
  endtask

  task automatic test_forfeit_wrap();
    set_weights(0, 1, 1, 3);
    do_reset();
    set_data();
    ack_i = 1'b1;
    req_i = 4'b1000;
    tick();
    nvec++;
    if (gnt_o !== 4'b1000) begin
      nerr++;
      $display("FAIL forfeit_own3: gnt=%b, want 1000", gnt_o);
    end
    req_i = 4'b0001;
    tick();
    nvec++;
    if (gnt_o !== 4'b0001 || data_o !== data_i[0]) begin
      nerr++;
      $display("FAIL forfeit_to0: gnt=%b data=%h, want gnt=0001 data=%h", gnt_o, data_o, data_i[0]);
    end
    req_i = 4'b1001;
    tick();
    nvec++;
    if (gnt_o !== 4'b1000 || m_gnt !== 4'b1000) begin
      nerr++;
      $display("FAIL wght0_as_1: gnt=%b, want 1000", gnt_o);
    end
  endtask

  task automatic test_back_to_back();
    set_weights(1, 1, 1, 1);
    do_reset();
    set_data();
    req_i = 4'b0100;
    ack_i = 1'b0;
    tick();
    req_i = 4'b1000;
    ack_i = 1'b1;
    tick();
    nvec++;
    if (gnt_o !== 4'b1000 || rdy_o !== 1'b1 || data_o !== data_i[3]) begin
      nerr++;
      $display("FAIL b2b_grant: gnt=%b rdy=%b data=%h, want gnt=1000 rdy=1 data=%h",
               gnt_o, rdy_o, data_o, data_i[3]);
    end
    req_i = 4'b0;
    tick();
    tick();
    nvec++;
    if (gnt_o !== 4'b0 || rdy_o !== 1'b0 || data_o !== data_i[3]) begin
      nerr++;
      $display("FAIL b2b_idle_ack: gnt=%b rdy=%b data=%h, want gnt=0000 rdy=0 data=%h",
               gnt_o, rdy_o, data_o, data_i[3]);
    end
  endtask

  task automatic test_async_reset();
    set_weights(1, 1, 1, 1);
    do_reset();
    set_data();
    req_i = 4'b0100;
    ack_i = 1'b0;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    nvec++;
    if (gnt_o !== 4'b0 || data_o !== 32'h0 || rdy_o !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: gnt=%b data=%h rdy=%b, want gnt=0000 data=0 rdy=0", gnt_o, data_o, rdy_o);
    end
    model_reset();
    req_i = 4'b1111;
    ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    nvec++;
    if (gnt_o !== 4'b0001 || data_o !== data_i[0] || rdy_o !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_first: gnt=%b data=%h rdy=%b, want gnt=0001 data=%h rdy=1",
               gnt_o, data_o, rdy_o, data_i[0]);
    end
  endtask

  task automatic test_random();
    set_weights(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_i = 4'($urandom_range(0, 15));
      ack_i = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) data_i[i] = $urandom;
      if ($urandom_range(0, 31) == 0) wght_i[$urandom_range(0, 3)] = 4'($urandom);
      tick();
      nvec++;
      if (gnt_o !== m_gnt || data_o !== m_data || rdy_o !== m_busy) begin
        nerr++;
        $display("FAIL random[%0d]: gnt=%b data=%h rdy=%b, want gnt=%b data=%h rdy=%b",
                 c, gnt_o, data_o, rdy_o, m_gnt, m_data, m_busy);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = 4'b0;
    ack_i  = 1'b0;
    test_reset();
    test_single();
    test_weighted();
    test_backpressure();
    test_forfeit_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
